instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, instruction memory, instruction register and field decode.
// Define FETCH_RANGE_TRAP_EN to trap on fetches beyond DEPTH; otherwise such fetches read zero.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              jmp,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [7:0]        imm8,
  output logic              fetch_valid,
  output logic              trap
);

  localparam int unsigned      IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DepthLim = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StPrime, StRun, StTrap} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_next;
  logic [15:0]       ir_q, ir_d, fetch_word;
  logic              fetch_valid_q, fetch_valid_d;
  logic              strobe, rd_in_range, wr_in_range;
  logic [15:0]       mem [DEPTH];

  assign strobe      = pc_en | jmp;
  assign rd_in_range = {1'b0, pc_next} < DepthLim;
  assign wr_in_range = {1'b0, prog_addr} < DepthLim;

  always_comb begin
    pc_next = pc_q;
    if (jmp) begin
      pc_next = ir_q[ADDR_W-1:0];
    end else if (pc_en) begin
      pc_next = pc_q + ADDR_W'(1);
    end
  end

  // Combinational array read; the write below lands at the edge, so a same-edge fetch sees old data.
  assign fetch_word = rd_in_range ? mem[pc_next[IdxW-1:0]] : 16'h0000;

  always_ff @(posedge clk) begin
    if (prog_we && wr_in_range) begin
      mem[prog_addr[IdxW-1:0]] <= prog_data;
    end
  end

`ifdef FETCH_RANGE_TRAP_EN
  logic trap_q, trap_d;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    fetch_valid_d = fetch_valid_q;
`ifdef FETCH_RANGE_TRAP_EN
    trap_d        = trap_q;
`endif
    unique case (state_q)
      StPrime: begin
        ir_d          = mem[0];
        fetch_valid_d = 1'b1;
        state_d       = StRun;
      end
      StRun: begin
        if (strobe) begin
          pc_d          = pc_next;
          ir_d          = fetch_word;
          fetch_valid_d = rd_in_range;
`ifdef FETCH_RANGE_TRAP_EN
          if (!rd_in_range) begin
            trap_d  = 1'b1;
            state_d = StTrap;
          end
`endif
        end
      end
      default: ;  // StTrap: frozen until reset
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StPrime;
      pc_q          <= '0;
      ir_q          <= '0;
      fetch_valid_q <= 1'b0;
`ifdef FETCH_RANGE_TRAP_EN
      trap_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      fetch_valid_q <= fetch_valid_d;
`ifdef FETCH_RANGE_TRAP_EN
      trap_q        <= trap_d;
`endif
    end
  end

`ifdef FETCH_RANGE_TRAP_EN
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign fetch_valid = fetch_valid_q;
  assign opcode      = ir_q[15:12];
  assign rd          = ir_q[11:8];
  assign rs1         = ir_q[7:4];
  assign rs2         = ir_q[3:0];
  assign imm8        = ir_q[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a full-size instance plus a DEPTH=16 instance for range cases.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  logic        pc_en = 0, jmp = 0, prog_we = 0;
  logic [7:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic [7:0]  imm8;
  logic        fetch_valid, trap;

  logic        s_pc_en = 0, s_jmp = 0, s_prog_we = 0;
  logic [7:0]  s_prog_addr = '0;
  logic [15:0] s_prog_data = '0;
  logic [7:0]  s_pc;
  logic [15:0] s_ir;
  logic [3:0]  s_opcode, s_rd, s_rs1, s_rs2;
  logic [7:0]  s_imm8;
  logic        s_fetch_valid, s_trap;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(8), .DEPTH(256)) u_dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .jmp(jmp), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .pc(pc), .ir(ir), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm8(imm8), .fetch_valid(fetch_valid), .trap(trap)
  );

  instr_fetch_unit #(.ADDR_W(8), .DEPTH(16)) u_small (
    .clk(clk), .reset(reset), .pc_en(s_pc_en), .jmp(s_jmp), .prog_we(s_prog_we),
    .prog_addr(s_prog_addr), .prog_data(s_prog_data), .pc(s_pc), .ir(s_ir),
    .opcode(s_opcode), .rd(s_rd), .rs1(s_rs1), .rs2(s_rs2), .imm8(s_imm8),
    .fetch_valid(s_fetch_valid), .trap(s_trap)
  );

  // One cycle on the full-size instance; outputs are settled when this returns.
  task automatic step(input logic e, input logic j, input logic we, input logic [7:0] a,
                      input logic [15:0] d);
    @(negedge clk);
    pc_en = e; jmp = j; prog_we = we; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    pc_en = 0; jmp = 0; prog_we = 0;
  endtask

  task automatic s_step(input logic e, input logic j, input logic we, input logic [7:0] a,
                        input logic [15:0] d);
    @(negedge clk);
    s_pc_en = e; s_jmp = j; s_prog_we = we; s_prog_addr = a; s_prog_data = d;
    @(posedge clk); #1;
    s_pc_en = 0; s_jmp = 0; s_prog_we = 0;
  endtask

  task automatic test_reset();
    logic [7:0]  addrs [12] = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h03, 8'h04, 8'h05, 8'hAA,
                                8'hBB, 8'hFF, 8'h12, 8'h07};
    logic [15:0] words [12] = '{16'hC312, 16'h1234, 16'hF040, 16'hD501, 16'h3000, 16'h4000,
                                16'hAAAA, 16'h7005, 16'h00FF, 16'h9ABC, 16'h0007, 16'h7777};
    #1;
    vectors++;
    if (pc !== 8'h00 || ir !== 16'h0000 || fetch_valid !== 1'b0 || trap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%h ir=%h fv=%b trap=%b want 00 0000 0 0",
               pc, ir, fetch_valid, trap);
    end
    vectors++;
    if ({opcode, rd, rs1, rs2, imm8} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_fields: got %h want 000000", {opcode, rd, rs1, rs2, imm8});
    end
    for (int i = 0; i < 12; i++) step(0, 0, 1, addrs[i], words[i]);
    s_step(0, 0, 1, 8'h00, 16'h000F);
    s_step(0, 0, 1, 8'h0F, 16'h5A5A);
    vectors++;
    if (pc !== 8'h00 || ir !== 16'h0000 || s_ir !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_hold: pc=%h ir=%h s_ir=%h want 00 0000 0000", pc, ir, s_ir);
    end
  endtask

  task automatic test_prime();
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL prime_early_fv: got %b want 0", fetch_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (fetch_valid !== 1'b1 || opcode !== 4'hC || rd !== 4'h3 || imm8 !== 8'h12 || pc !== 8'h00)
    begin
      miscompares++;
      $display("FAIL prime: fv=%b op=%h rd=%h imm8=%h pc=%h want 1 c 3 12 00",
               fetch_valid, opcode, rd, imm8, pc);
    end
    vectors++;
    if (rs1 !== 4'h1 || rs2 !== 4'h2 || s_ir !== 16'h000F) begin
      miscompares++;
      $display("FAIL prime_fields: rs1=%h rs2=%h s_ir=%h want 1 2 000f", rs1, rs2, s_ir);
    end
  endtask

  task automatic test_sequential();
    step(1, 0, 0, 8'h00, 16'h0);
    vectors++;
    if (pc !== 8'h01 || ir !== 16'h1234) begin
      miscompares++;
      $display("FAIL seq_fetch: pc=%h ir=%h want 01 1234", pc, ir);
    end
    step(0, 0, 0, 8'h00, 16'h0);
    step(0, 0, 0, 8'h00, 16'h0);
    vectors++;
    if (pc !== 8'h01 || ir !== 16'h1234 || fetch_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL seq_hold: pc=%h ir=%h fv=%b want 01 1234 1", pc, ir, fetch_valid);
    end
  endtask

  task automatic test_jump();
    step(1, 0, 0, 8'h00, 16'h0);
    vectors++;
    if (pc !== 8'h02 || ir !== 16'hF040) begin
      miscompares++;
      $display("FAIL jmp_setup: pc=%h ir=%h want 02 f040", pc, ir);
    end
    step(0, 1, 0, 8'h00, 16'h0);
    vectors++;
    if (pc !== 8'h40 || opcode !== 4'hD || ir !== 16'hD501) begin
      miscompares++;
      $display("FAIL jmp: pc=%h op=%h ir=%h want 40 d d501", pc, opcode, ir);
    end
    step(0, 1, 0, 8'h00, 16'h0);
    step(1, 0, 0, 8'h00, 16'h0);
    step(1, 1, 0, 8'h00, 16'h0);
    vectors++;
    if (pc !== 8'h40 || opcode !== 4'hD) begin
      miscompares++;
      $display("FAIL jmp_priority: pc=%h op=%h want 40 d", pc, opcode);
    end
  endtask

  task automatic test_collision();
    step(0, 1, 0, 8'h00, 16'h0);
    step(1, 0, 0, 8'h00, 16'h0);
    step(1, 0, 0, 8'h00, 16'h0);
    step(1, 0, 0, 8'h00, 16'h0);
    vectors++;
    if (pc !== 8'h04 || ir !== 16'h4000) begin
      miscompares++;
      $display("FAIL coll_setup: pc=%h ir=%h want 04 4000", pc, ir);
    end
    step(1, 0, 1, 8'h05, 16'hBBBB);
    vectors++;
    if (pc !== 8'h05 || ir !== 16'hAAAA) begin
      miscompares++;
      $display("FAIL coll_old_word: pc=%h ir=%h want 05 aaaa", pc, ir);
    end
    step(0, 1, 0, 8'h00, 16'h0);
    step(0, 1, 0, 8'h00, 16'h0);
    vectors++;
    if (pc !== 8'h05 || ir !== 16'hBBBB) begin
      miscompares++;
      $display("FAIL coll_new_word: pc=%h ir=%h want 05 bbbb", pc, ir);
    end
    step(0, 0, 1, 8'h05, 16'hCCCC);
    vectors++;
    if (ir !== 16'hBBBB) begin
      miscompares++;
      $display("FAIL write_no_refresh: ir=%h want bbbb", ir);
    end
  endtask

  task automatic test_wrap();
    step(0, 1, 0, 8'h00, 16'h0);
    step(0, 1, 0, 8'h00, 16'h0);
    vectors++;
    if (pc !== 8'hFF || ir !== 16'h9ABC) begin
      miscompares++;
      $display("FAIL wrap_setup: pc=%h ir=%h want ff 9abc", pc, ir);
    end
    step(1, 0, 0, 8'h00, 16'h0);
    vectors++;
    if (pc !== 8'h00 || ir !== 16'hC312) begin
      miscompares++;
      $display("FAIL wrap: pc=%h ir=%h want 00 c312", pc, ir);
    end
  endtask

  task automatic test_reset_mid_run();
    step(0, 1, 0, 8'h00, 16'h0);
    step(0, 1, 0, 8'h00, 16'h0);
    vectors++;
    if (pc !== 8'h07 || ir !== 16'h7777) begin
      miscompares++;
      $display("FAIL rst_setup: pc=%h ir=%h want 07 7777", pc, ir);
    end
    @(negedge clk);
    pc_en = 1; reset = 0;
    #1;
    vectors++;
    if (pc !== 8'h00 || ir !== 16'h0000 || fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: pc=%h ir=%h fv=%b want 00 0000 0", pc, ir, fetch_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (pc !== 8'h00 || ir !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_strobe_lost: pc=%h ir=%h want 00 0000", pc, ir);
    end
    @(negedge clk);
    pc_en = 0; reset = 1;
    @(posedge clk); #1;
    vectors++;
    if (pc !== 8'h00 || ir !== 16'hC312 || fetch_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_reprime: pc=%h ir=%h fv=%b want 00 c312 1", pc, ir, fetch_valid);
    end
  endtask

  task automatic test_range();
    s_step(0, 1, 0, 8'h00, 16'h0);
    vectors++;
    if (s_pc !== 8'h0F || s_ir !== 16'h5A5A || s_trap !== 1'b0) begin
      miscompares++;
      $display("FAIL range_setup: pc=%h ir=%h trap=%b want 0f 5a5a 0", s_pc, s_ir, s_trap);
    end
    s_step(1, 0, 0, 8'h00, 16'h0);
`ifdef FETCH_RANGE_TRAP_EN
    vectors++;
    if (s_pc !== 8'h10 || s_ir !== 16'h0000 || s_trap !== 1'b1 || s_fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL range_trap: pc=%h ir=%h trap=%b fv=%b want 10 0000 1 0",
               s_pc, s_ir, s_trap, s_fetch_valid);
    end
    s_step(1, 0, 1, 8'h01, 16'h1111);
    s_step(0, 1, 0, 8'h00, 16'h0);
    vectors++;
    if (s_pc !== 8'h10 || s_ir !== 16'h0000 || s_trap !== 1'b1) begin
      miscompares++;
      $display("FAIL trap_hold: pc=%h ir=%h trap=%b want 10 0000 1", s_pc, s_ir, s_trap);
    end
    @(negedge clk);
    reset = 0;
    #1;
    vectors++;
    if (s_trap !== 1'b0 || s_pc !== 8'h00) begin
      miscompares++;
      $display("FAIL trap_reset: trap=%b pc=%h want 0 00", s_trap, s_pc);
    end
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    vectors++;
    if (s_ir !== 16'h000F || s_trap !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_reprime: ir=%h trap=%b want 000f 0", s_ir, s_trap);
    end
`else
    vectors++;
    if (s_pc !== 8'h10 || s_ir !== 16'h0000 || s_trap !== 1'b0 || s_fetch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL range_zero: pc=%h ir=%h trap=%b fv=%b want 10 0000 0 0",
               s_pc, s_ir, s_trap, s_fetch_valid);
    end
    s_step(1, 0, 0, 8'h00, 16'h0);
    vectors++;
    if (s_pc !== 8'h11 || s_ir !== 16'h0000) begin
      miscompares++;
      $display("FAIL range_cont: pc=%h ir=%h want 11 0000", s_pc, s_ir);
    end
    s_step(0, 1, 0, 8'h00, 16'h0);
    vectors++;
    if (s_pc !== 8'h00 || s_ir !== 16'h000F || s_fetch_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL range_return: pc=%h ir=%h fv=%b want 00 000f 1", s_pc, s_ir, s_fetch_valid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_prime();
    test_sequential();
    test_jump();
    test_collision();
    test_wrap();
    test_reset_mid_run();
    test_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
